// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit blocks.
//   rx_state_e     - receive framing state machine encoding
//   DEF_OVERSAMPLE - default number of oversample ticks per bit
//   PARITY_EVEN/ODD - encodings for the parity-select input
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// baud_tick: programmable oversample tick divider, shared by RX and TX.
// Ports:
//   clk    - clock
//   rstn   - synchronous active-low reset
//   i_clr  - hold the counter at 0 (phase alignment to a start edge)
//   i_div  - clocks per tick minus 1
//   o_tick - high for one clock each time the counter reaches i_div
module baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Wrap on >= so a divisor lowered below the current count cannot run
  // the counter through its full range before the next tick.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (i_clr || (cnt_q >= i_div)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == i_div);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: receive-side UART deserializer feeding the RX FIFO write port.
// Synchronizes i_rxd, oversamples it from baud_tick, frames
// start/data/parity/stop and writes good bytes to the FIFO.
// Ports:
//   clk, rstn      - clock, synchronous active-low reset
//   i_div          - clocks per oversample tick minus 1
//   i_parity_en    - parity bit present after the data bits
//   i_parity_odd   - 1 = odd parity, 0 = even parity
//   i_rxd          - asynchronous serial line (idles high)
//   i_wfull        - FIFO full flag
//   o_wen/o_wdata  - one-cycle FIFO write strobe and its byte
//   o_frame_err    - pulse: stop bit sampled low
//   o_parity_err   - pulse: parity mismatch on an otherwise good frame
//   o_break        - pulse: data, parity and stop all sampled low
//   o_drop         - pulse: good byte discarded because the FIFO was full
//   o_busy         - high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DIV_W-1:0]     i_div,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_rxd,
  input  logic                 i_wfull,
  output logic                 o_wen,
  output logic [DATA_BITS-1:0] o_wdata,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break,
  output logic                 o_drop,
  output logic                 o_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  // Synchronizer and edge-detect stage; reset high so a reset never
  // looks like a start edge.
  logic sync1_q, sync2_q, rx_prev_q;
  logic rx, fall, tick;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_rxd;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx   = sync2_q;
  assign fall = rx_prev_q & ~rx;

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        b_cnt_q, b_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 par_err;

  logic                 wen_q, wen_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 brk_q, brk_d;
  logic                 drop_q, drop_d;
  logic                 busy_q, busy_d;

  // Divider held at zero while idle so tick phase follows the start edge.
  baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (state_q == RX_IDLE),
    .i_div  (i_div),
    .o_tick (tick)
  );

  assign par_err = par_en_q && ((^shreg_q ^ par_bit_q) != par_odd_q);

  // Framing state machine: next state, counters and output pulses.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    b_cnt_d   = b_cnt_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    brk_d     = 1'b0;
    drop_d    = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d   = RX_START;
          s_cnt_d   = '0;
          b_cnt_d   = '0;
          par_bit_d = 1'b0;
          par_en_d  = i_parity_en;
          par_odd_d = i_parity_odd;
        end
      end

      RX_START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            s_cnt_d = '0;
            // Line back high at mid-start: treat as a glitch.
            state_d = rx ? RX_IDLE : RX_DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      RX_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            s_cnt_d = '0;
            shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
            if (b_cnt_q == B_LAST) begin
              state_d = par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              b_cnt_d = b_cnt_q + BW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      RX_PARITY: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            s_cnt_d   = '0;
            par_bit_d = rx;
            state_d   = RX_STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      RX_STOP: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            s_cnt_d = '0;
            if (!rx) begin
              // Framing error dominates parity; a break also needs every
              // data/parity bit low.
              ferr_d  = 1'b1;
              brk_d   = (shreg_q == '0) && !(par_en_q && par_bit_q);
              state_d = RX_WAIT_HIGH;
            end else begin
              state_d = RX_IDLE;
              if (par_err) begin
                perr_d = 1'b1;
              end else if (i_wfull) begin
                drop_d = 1'b1;
              end else begin
                wen_d   = 1'b1;
                wdata_d = shreg_q;
              end
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      RX_WAIT_HIGH: begin
        if (rx) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase

    busy_d = (state_d != RX_IDLE);
  end

  // State and registered-output stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= RX_IDLE;
      s_cnt_q   <= '0;
      b_cnt_q   <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      brk_q     <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      b_cnt_q   <= b_cnt_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      brk_q     <= brk_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  assign o_wen        = wen_q;
  assign o_wdata      = wdata_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_break      = brk_q;
  assign o_drop       = drop_q;
  assign o_busy       = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side UART deserializer that feeds the RX FIFO's write port. It synchronizes the asynchronous serial input and oversamples it at 16x from a programmable divider. It frames start/data/parity/stop bits and writes each good byte into the FIFO as a single-cycle write strobe with data. Errors and bytes dropped because the FIFO is full are reported as single-cycle pulses to the status/interrupt logic.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame (5–8), LSB first
- OVERSAMPLE, 16, ticks per bit; even, ≥4
- DIV_W, 16, width of the baud divisor

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_div  in  DIV_W  clocks per oversample tick minus 1
- i_parity_en  in  1  parity bit present after data
- i_parity_odd  in  1  1 = odd parity, 0 = even parity
- i_rxd  in  1  asynchronous serial line, idles high
- i_wfull  in  1  FIFO full flag, from the write-pointer stage
- o_wen  out  1  FIFO write strobe, one cycle per accepted byte
- o_wdata  out  DATA_BITS  byte to write; valid while o_wen is high
- o_frame_err  out  1  pulse: stop bit sampled low
- o_parity_err  out  1  pulse: parity mismatch
- o_break  out  1  pulse: all data bits, parity and stop sampled low
- o_drop  out  1  pulse: good byte discarded because i_wfull was high
- o_busy  out  1  high in any state except IDLE

## Operation
- Synchronizer: 2 flops on i_rxd, both reset to 1. All logic uses the synced value `rx`.
- Tick generator:
  - Counter runs 0..i_div and pulses `tick` when count == i_div.
  - Counter is held at 0 in IDLE, so phase aligns to the start edge.
  - i_div changes take effect immediately; software changes it only while o_busy is low.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. The sample counter is s_cnt; the bit counter is b_cnt.
- IDLE: falling edge on `rx` (previous 1, current 0) → START, with s_cnt = 0 and b_cnt = 0.
- START: on the tick where s_cnt == OVERSAMPLE/2-1, sample `rx`.
  - 1 → IDLE (glitch, no outputs).
  - 0 → DATA, with s_cnt = 0.
- DATA: sample on each tick where s_cnt == OVERSAMPLE-1 and shift into the data register, LSB first.
  - After bit DATA_BITS-1 → PARITY if i_parity_en, else STOP.
- PARITY: sample at the same point. Error if XOR(data, parity bit) ≠ i_parity_odd.
- STOP: sample at the same point, then act on the result.
  - Stop = 1, no parity error: if ~i_wfull, pulse o_wen with o_wdata; else pulse o_drop. → IDLE.
  - Stop = 1, parity error: pulse o_parity_err, no write. → IDLE.
  - Stop = 0: pulse o_frame_err, plus o_break if data and parity bit were all 0. No write, and o_parity_err is suppressed. → WAIT_HIGH.
- WAIT_HIGH: stay until `rx` == 1, then → IDLE. This keeps a held break from retriggering.
- i_parity_en and i_parity_odd are sampled at the start edge and held for the frame.

## Timing
- Reset values: o_wen, o_frame_err, o_parity_err, o_break, o_drop, o_busy = 0; o_wdata = 0; state = IDLE; all counters = 0.
- All outputs are registered. Each status pulse is exactly 1 cycle.
- Write timing:
  - o_wen is high in the cycle after the stop-sample tick.
  - i_wfull is evaluated in the stop-sample cycle.
  - o_wen is never asserted while i_wfull = 1, so the FIFO overflow flag never sets from this source.
- Input latency: 2 clk synchronizer plus 1 clk edge detect, from an i_rxd transition to the state change.
- Frame length: the stop sample lands (1 + DATA_BITS + parity + 0.5) × OVERSAMPLE × (i_div+1) clk after edge detection. Returning to IDLE at mid-stop tolerates about ½ bit of baud mismatch.
- Reset mid-frame: the frame is aborted, all pulses are suppressed, and the block returns to IDLE next cycle.

## Structure
- Shared package uart_pkg holds:
  - rx state enum `rx_state_e`
  - default `OVERSAMPLE`
  - parity-mode constants
- Sub-module baud_tick (parameter DIV_W; ports clk, rstn, i_clr, i_div, o_tick) implements the divider. TX reuses it.

## Test plan
- i_div=0, 8N1, send 0xA5 → o_wen one cycle with o_wdata=0xA5 at edge+3+152 clk; no error pulses.
- Even parity on, send 0x03 with parity bit 1 → o_parity_err pulse, no o_wen. Resend with parity bit 0 → o_wen with 0x03.
- Stop bit forced 0, data 0x55 → o_frame_err, no o_wen. Hold line low 40 bits (break) → one o_break, then recovery after the line rises and the next 0x12 is received.
- i_wfull=1 through a 0x7E frame → o_drop pulse, o_wen stays 0. Release i_wfull, send 0x7E → written.
- Low glitch of 4 ticks (i_div=3) → no state beyond START, o_busy falls, no pulses.
- Assert rstn=0 during bit 3 of a frame → all outputs 0 next cycle. The following 0xC3 frame is received correctly.
